// File: rtl/dlx_pkg.sv
// Shared types for the DLX fetch path: PC command encoding, fetch FSM states, redirect slot.
package dlx_pkg;

    localparam int unsigned PC_ADDR_W = 32;

    typedef enum logic [1:0] {
        PC_SEQ  = 2'b00,
        PC_TRAP = 2'b01,
        PC_REL  = 2'b10,
        PC_ABS  = 2'b11
    } pc_cmd_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } pc_state_e;

    typedef struct packed {
        pc_cmd_e                cmd;
        logic [PC_ADDR_W-1:0]   v;
    } pc_pend_t;

endpackage

// File: rtl/pc_fetch_ctrl_target.sv
// Next-fetch target computation with alignment handling.
// Optional macro PC_MISALIGN_TRAP_EN: misaligned targets redirect to TRAP_VEC and flag misalign_c;
// otherwise the low alignment bits are cleared and misalign_c is tied low.
module pc_target
    import dlx_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        INSTR_B   = 4,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC  = ADDR_W'(32'h0000_0100)
) (
    input  pc_cmd_e               cmd,
    input  logic [ADDR_W-1:0]     v,
    input  logic [ADDR_W-1:0]     last,
    input  logic                  first,
    output logic [ADDR_W-1:0]     target_c,
    output logic                  misalign_c
);

    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INSTR_B);
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INSTR_B - 1);

    logic [ADDR_W-1:0] raw;

    // Unaligned target from the command; sums wrap modulo 2^ADDR_W.
    always_comb begin
        raw = last + STEP;
        case (cmd)
            PC_SEQ:  raw = first ? RESET_VEC : last + STEP;
            PC_TRAP: raw = TRAP_VEC;
            PC_REL:  raw = last + v;
            PC_ABS:  raw = v;
            default: raw = last + STEP;
        endcase
    end

`ifdef PC_MISALIGN_TRAP_EN
    // Misaligned target is replaced by the trap vector.
    always_comb begin
        misalign_c = |(raw & LOW_MASK);
        target_c   = misalign_c ? TRAP_VEC : raw;
    end
`else
    // Misaligned target is silently aligned down.
    always_comb begin
        misalign_c = 1'b0;
        target_c   = raw & ~LOW_MASK;
    end
`endif

endmodule

// File: rtl/pc_fetch_ctrl.sv
// DLX program counter / fetch request unit with one-entry redirect buffer during imem stalls.
// Optional macro PC_MISALIGN_TRAP_EN enables trapping on misaligned fetch targets.
module pc_fetch_ctrl
    import dlx_pkg::*;
#(
    parameter int unsigned        ADDR_W    = 32,
    parameter int unsigned        INSTR_B   = 4,
    parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
    parameter logic [ADDR_W-1:0]  TRAP_VEC  = ADDR_W'(32'h0000_0100)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  IF,
    input  logic [1:0]            pc_cmd,
    input  logic [ADDR_W-1:0]     pc_v,
    input  logic                  i_ready,
    output logic                  i_req,
    output logic [ADDR_W-1:0]     i_address,
    output logic [ADDR_W-1:0]     pc_link,
    output logic                  busy,
    output logic                  misalign
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_B);

    pc_state_e          state_q, state_d;
    pc_pend_t           slot_q, slot_d;
    logic               first_q, first_d;
    logic               req_d, busy_d, mis_d;
    logic [ADDR_W-1:0]  addr_d, link_d;
    logic               issue, use_pend;
    pc_cmd_e            t_cmd;
    logic [ADDR_W-1:0]  t_v;
    logic [ADDR_W-1:0]  target_c;
    logic               mis_c;

    // Select the issuing command: buffered redirect has priority over a fresh IF.
    always_comb begin
        use_pend = (state_q == WAIT) && i_ready && busy;
        t_cmd    = use_pend ? slot_q.cmd : pc_cmd_e'(pc_cmd);
        t_v      = use_pend ? ADDR_W'(slot_q.v) : pc_v;
    end

    pc_target #(
        .ADDR_W    (ADDR_W),
        .INSTR_B   (INSTR_B),
        .RESET_VEC (RESET_VEC),
        .TRAP_VEC  (TRAP_VEC)
    ) u_target (
        .cmd        (t_cmd),
        .v          (t_v),
        .last       (i_address),
        .first      (first_q),
        .target_c   (target_c),
        .misalign_c (mis_c)
    );

    // Fetch FSM next-state and output computation.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        first_d = first_q;
        req_d   = i_req;
        busy_d  = busy;
        addr_d  = i_address;
        link_d  = pc_link;
        mis_d   = 1'b0;
        issue   = 1'b0;

        case (state_q)
            IDLE: begin
                if (IF) begin
                    issue   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_ready) begin
                    if (busy) begin
                        issue  = 1'b1;
                        busy_d = 1'b0;
                        if (IF) begin
                            slot_d.cmd = pc_cmd_e'(pc_cmd);
                            slot_d.v   = PC_ADDR_W'(pc_v);
                            busy_d     = 1'b1;
                        end
                    end else if (IF) begin
                        issue = 1'b1;
                    end else begin
                        req_d   = 1'b0;
                        state_d = IDLE;
                    end
                end else if (IF && !busy) begin
                    slot_d.cmd = pc_cmd_e'(pc_cmd);
                    slot_d.v   = PC_ADDR_W'(pc_v);
                    busy_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            addr_d  = target_c;
            link_d  = target_c + STEP;
            req_d   = 1'b1;
            first_d = 1'b0;
            mis_d   = mis_c;
        end
    end

    // State and registered outputs; reset abandons any outstanding request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            first_q   <= 1'b1;
            i_req     <= 1'b0;
            i_address <= RESET_VEC;
            pc_link   <= RESET_VEC + STEP;
            busy      <= 1'b0;
            misalign  <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            first_q   <= first_d;
            i_req     <= req_d;
            i_address <= addr_d;
            pc_link   <= link_d;
            busy      <= busy_d;
            misalign  <= mis_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: transaction-level reference model plus literal checks.
module tb_pc_fetch_ctrl;

    localparam logic [1:0] SEQ  = 2'b00;
    localparam logic [1:0] TRAP = 2'b01;
    localparam logic [1:0] REL  = 2'b10;
    localparam logic [1:0] ABS  = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_s;
    logic [1:0]  cmd;
    logic [31:0] pv;
    logic        rdy;
    logic        i_req;
    logic [31:0] i_address;
    logic [31:0] pc_link;
    logic        busy;
    logic        misalign;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .IF        (if_s),
        .pc_cmd    (cmd),
        .pc_v      (pv),
        .i_ready   (rdy),
        .i_req     (i_req),
        .i_address (i_address),
        .pc_link   (pc_link),
        .busy      (busy),
        .misalign  (misalign)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding fetch plus a queue of at most one redirect.
    logic        m_req, m_first, m_mis;
    logic [31:0] m_addr, m_link;
    logic [1:0]  q_cmd[$];
    logic [31:0] q_v[$];

    function automatic void m_issue(input logic [1:0] c, input logic [31:0] v);
        logic [31:0] t;
        case (c)
            SEQ:     t = m_first ? 32'h0 : m_addr + 32'd4;
            TRAP:    t = 32'h100;
            REL:     t = m_addr + v;
            default: t = v;
        endcase
`ifdef PC_MISALIGN_TRAP_EN
        m_mis = (t % 4) != 0;
        if (m_mis) t = 32'h100;
`else
        t = t - (t % 4);
`endif
        m_addr  = t;
        m_link  = t + 32'd4;
        m_req   = 1'b1;
        m_first = 1'b0;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_req = 1'b0; m_first = 1'b1; m_mis = 1'b0;
            m_addr = 32'h0; m_link = 32'h4;
            q_cmd.delete(); q_v.delete();
        end else begin
            m_mis = 1'b0;
            if (!m_req) begin
                if (if_s) m_issue(cmd, pv);
            end else if (rdy) begin
                if (q_cmd.size() != 0) begin
                    m_issue(q_cmd.pop_front(), q_v.pop_front());
                    if (if_s) begin q_cmd.push_back(cmd); q_v.push_back(pv); end
                end else if (if_s) begin
                    m_issue(cmd, pv);
                end else begin
                    m_req = 1'b0;
                end
            end else if (if_s) begin
                if (q_cmd.size() == 0) begin q_cmd.push_back(cmd); q_v.push_back(pv); end
                else chk("protocol_if_while_busy", 32'd1, 32'd0);
            end
        end
    end

    // Every-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("m_i_req",     32'(i_req),    32'(m_req));
            chk("m_i_address", i_address,     m_addr);
            chk("m_pc_link",   pc_link,       m_link);
            chk("m_busy",      32'(busy),     32'(q_cmd.size() != 0));
            chk("m_misalign",  32'(misalign), 32'(m_mis));
        end
    end

    task automatic step(input logic f, input logic [1:0] c, input logic [31:0] v, input logic r);
        if_s = f; cmd = c; pv = v; rdy = r;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; if_s = 1'b0; cmd = SEQ; pv = '0; rdy = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_i_req", 32'(i_req), 32'd0);
        chk("rst_addr",  i_address,  32'h0);
        chk("rst_link",  pc_link,    32'h4);
        chk("rst_busy",  32'(busy),  32'd0);
        reset_n = 1'b1;

        // Sequential fetches after reset
        step(1'b1, SEQ, 32'h0, 1'b1);  chk("seq0", i_address, 32'h0);
        chk("seq0_req", 32'(i_req), 32'd1);
        step(1'b1, SEQ, 32'h0, 1'b1);  chk("seq1", i_address, 32'h4);
        step(1'b1, SEQ, 32'h0, 1'b1);  chk("seq2", i_address, 32'h8);

        // Redirects
        step(1'b1, ABS,  32'h40,        1'b1); chk("abs40", i_address, 32'h40);
        step(1'b1, REL,  32'hFFFF_FFF8, 1'b1); chk("rel_m8", i_address, 32'h38);
        step(1'b1, ABS,  32'h1000,      1'b1); chk("abs1000", i_address, 32'h1000);
        chk("abs1000_link", pc_link, 32'h1004);
        step(1'b1, TRAP, 32'h0,         1'b1); chk("trap", i_address, 32'h100);
        step(1'b0, SEQ,  32'h0,         1'b1); chk("idle_req", 32'(i_req), 32'd0);

        // Stall with buffered ABS redirect
        step(1'b1, ABS, 32'h80,  1'b0); chk("stall_first", i_address, 32'h80);
        step(1'b1, ABS, 32'h200, 1'b0); chk("stall_busy", 32'(busy), 32'd1);
        step(1'b0, SEQ, 32'h0,   1'b0);
        step(1'b0, SEQ, 32'h0,   1'b0); chk("stall_hold", i_address, 32'h80);
        chk("stall_busy2", 32'(busy), 32'd1);
        step(1'b0, SEQ, 32'h0,   1'b1); chk("pend_abs", i_address, 32'h200);
        chk("pend_busy0", 32'(busy), 32'd0);
        step(1'b0, SEQ, 32'h0,   1'b1);

        // Buffered REL is relative to the address current at its issue
        step(1'b1, ABS, 32'h300, 1'b0);
        step(1'b1, REL, 32'h10,  1'b0);
        step(1'b0, SEQ, 32'h0,   1'b1); chk("pend_rel", i_address, 32'h310);
        step(1'b0, SEQ, 32'h0,   1'b1);

        // Address wrap
        step(1'b1, ABS, 32'hFFFF_FFFC, 1'b1); chk("wrap_link", pc_link, 32'h0);
        step(1'b1, SEQ, 32'h0,         1'b1); chk("wrap_seq", i_address, 32'h0);
        step(1'b1, ABS, 32'hFFFF_FFFC, 1'b1);
        step(1'b1, REL, 32'h8,         1'b1); chk("wrap_rel", i_address, 32'h4);
        step(1'b0, SEQ, 32'h0,         1'b1);

        // Misaligned target
        step(1'b1, ABS, 32'h1002, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_addr", i_address, 32'h100);
        chk("mis_flag", 32'(misalign), 32'd1);
`else
        chk("mis_addr", i_address, 32'h1000);
        chk("mis_flag", 32'(misalign), 32'd0);
`endif
        step(1'b0, SEQ, 32'h0, 1'b1);
        chk("mis_pulse_end", 32'(misalign), 32'd0);

        // Asynchronous reset while waiting with a buffered redirect
        step(1'b1, ABS, 32'h500, 1'b0);
        step(1'b1, SEQ, 32'h0,   1'b0); chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_req",  32'(i_req), 32'd0);
        chk("arst_addr", i_address,  32'h0);
        chk("arst_busy", 32'(busy),  32'd0);
        chk("arst_link", pc_link,    32'h4);
        if_s = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        step(1'b1, SEQ, 32'h0, 1'b1); chk("post_rst_seq", i_address, 32'h0);
        step(1'b0, SEQ, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
